// File: rtl/wc_pkg.sv
// Shared widths and tap constants for the wc 4-tap correlator.
package wc_pkg;

  // Sample width, counts, and the internal full-precision accumulator width.
  // 14 bits covers the worst case |sum| = 7 * 512 = 3584 with room to spare.
  localparam int SW   = 10;
  localparam int NIN  = 8;
  localparam int NOUT = 5;
  localparam int NTAP = 4;
  localparam int ACCW = 14;

  // Fixed correlation taps g0..g3 = 1, 2, -1, 3.
  localparam logic signed [ACCW-1:0] G0 = 14'sd1;
  localparam logic signed [ACCW-1:0] G1 = 14'sd2;
  localparam logic signed [ACCW-1:0] G2 = -14'sd1;
  localparam logic signed [ACCW-1:0] G3 = 14'sd3;

  // Tap lookup by index so generate loops can walk the taps.
  function automatic logic signed [ACCW-1:0] tap(input int k);
    logic signed [ACCW-1:0] t;
    t = '0;
    case (k)
      0:       t = G0;
      1:       t = G1;
      2:       t = G2;
      3:       t = G3;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/wc_dot4.sv
// Combinational 4-sample x fixed-tap dot product, split around a register
// boundary owned by the caller: the product half feeds the caller's product
// register, and the sum half consumes that register and wraps to SW bits.
module wc_dot4 import wc_pkg::*; (
  input  logic [NTAP*SW-1:0]   s,       // samples, first sample in the MSBs
  output logic [NTAP*ACCW-1:0] prod,    // full-precision products, tap 0 in MSBs
  input  logic [NTAP*ACCW-1:0] prod_q,  // registered products
  output logic [SW-1:0]        y        // wrapped sum of registered products
);

  logic signed [ACCW-1:0] sum;
  logic                   unused_hi;

  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
      logic signed [SW-1:0]   samp;
      logic signed [ACCW-1:0] ext;
      logic signed [ACCW-1:0] p;
      assign samp = s[(NTAP-gi)*SW-1 -: SW];
      assign ext  = {{(ACCW-SW){samp[SW-1]}}, samp};
      assign p    = ext * tap(gi);
      assign prod[(NTAP-gi)*ACCW-1 -: ACCW] = p;
    end
  endgenerate

  // Full-precision sum of the registered products.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAP; k++) begin
      sum = sum + signed'(prod_q[(NTAP-k)*ACCW-1 -: ACCW]);
    end
  end

  // Result wraps modulo 2^SW; the upper accumulator bits are intentionally dropped.
  assign y         = sum[SW-1:0];
  assign unused_hi = ^sum[ACCW-1:SW];

endmodule

// File: rtl/wc.sv
// wc: 4-tap valid correlation of eight signed samples into five wrapped
// results. Four register stages: input, products, wrapped sums, output.
module wc import wc_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic [NIN*SW-1:0]  D,
  output logic [NOUT*SW-1:0] Z
);

  logic [NIN*SW-1:0]   d_reg;
  logic [NOUT*SW-1:0]  sum_reg;
  logic [NOUT*SW-1:0]  z_reg;

  // Stage 1: capture the whole input word every cycle.
  always_ff @(posedge clk) begin
    if (rst) d_reg <= '0;
    else     d_reg <= D;
  end

  generate
    for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
      logic [NTAP*ACCW-1:0] prod_next;
      logic [NTAP*ACCW-1:0] prod_reg;
      logic [SW-1:0]        y_next;

      // Output gi correlates samples gi..gi+3.
      wc_dot4 u_dot4 (
        .s      (d_reg[(NIN-gi)*SW-1 -: NTAP*SW]),
        .prod   (prod_next),
        .prod_q (prod_reg),
        .y      (y_next)
      );

      // Stage 2: register full-precision products.
      always_ff @(posedge clk) begin
        if (rst) prod_reg <= '0;
        else     prod_reg <= prod_next;
      end

      // Stage 3: register the wrapped sum for this output lane.
      always_ff @(posedge clk) begin
        if (rst) sum_reg[(NOUT-gi)*SW-1 -: SW] <= '0;
        else     sum_reg[(NOUT-gi)*SW-1 -: SW] <= y_next;
      end
    end
  endgenerate

  // Stage 4: output register so Z only moves on clock edges.
  always_ff @(posedge clk) begin
    if (rst) z_reg <= '0;
    else     z_reg <= sum_reg;
  end

  assign Z = z_reg;

endmodule

// File: tb/tb_wc.sv
// Directed bench for wc: reset, latency, wrap boundaries, streaming and
// mid-stream reset, checked with immediate assertions.
module tb_wc;

  typedef int d8_t[8];
  typedef int y5_t[5];

  logic        clk;
  logic        rst;
  logic [79:0] D;
  logic [49:0] Z;

  int n_checks;
  int n_fail;

  wc dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .Z   (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pack_d(input d8_t a);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[79-10*i -: 10] = a[i][9:0];
    return r;
  endfunction

  function automatic logic [49:0] pack_y(input y5_t a);
    logic [49:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[49-10*i -: 10] = a[i][9:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [49:0] exp);
    n_checks++;
    assert (Z === exp) else begin
      n_fail++;
      $error("FAIL %s: Z=%h expected %h", tag, Z, exp);
    end
    $display("check %-14s Z=%h expected %h", tag, Z, exp);
  endtask

  initial begin
    d8_t v1, v2, vpos, vneg;
    y5_t e1, e2, epos, eneg;
    logic [49:0] y1, y2, ypos, yneg, yzero;

    n_checks = 0;
    n_fail   = 0;

    v1   = '{2, -10, 3, 4, -13, -18, -16, -28};
    e1   = '{-9, -47, -30, -52, -117};
    v2   = '{-19, -6, 3, -9, -12, 11, -4, 0};
    e2   = '{-61, -27, 30, -56, 14};
    vpos = '{511, 511, 511, 511, 511, 511, 511, 511};
    epos = '{507, 507, 507, 507, 507};
    vneg = '{-512, -512, -512, -512, -512, -512, -512, -512};
    eneg = '{-512, -512, -512, -512, -512};
    y1    = pack_y(e1);
    y2    = pack_y(e2);
    ypos  = pack_y(epos);
    yneg  = pack_y(eneg);
    yzero = '0;

    // Reset held two cycles with nonzero data on D.
    rst = 1'b1;
    D   = pack_d(v1);
    tick();
    check("reset_c1", yzero);
    tick();
    check("reset_c2", yzero);

    // Release; Z stays 0 until the first sample has crossed 4 stages.
    rst = 1'b0;
    tick();
    check("post_rst_1", yzero);
    tick();
    check("post_rst_2", yzero);
    tick();
    check("post_rst_3", yzero);
    tick();
    check("vec1", y1);
    tick();
    check("vec1_hold", y1);

    // Vector 2: not visible after 3 edges, visible after the 4th.
    D = pack_d(v2);
    tick();
    tick();
    tick();
    check("vec2_early", y1);
    tick();
    check("vec2", y2);
    tick();
    tick();
    check("vec2_hold", y2);

    // Wrap boundaries.
    D = pack_d(vpos);
    repeat (4) tick();
    check("all_pos", ypos);
    D = pack_d(vneg);
    repeat (4) tick();
    check("all_neg", yneg);

    // Streaming on consecutive cycles.
    D = pack_d(v1);
    tick();
    D = pack_d(v2);
    tick();
    D = pack_d(vpos);
    tick();
    D = pack_d(vneg);
    tick();
    check("stream_v1", y1);
    tick();
    check("stream_v2", y2);
    tick();
    check("stream_pos", ypos);
    tick();
    check("stream_neg", yneg);

    // Mid-stream reset flushes everything in flight.
    D = pack_d(v1);
    tick();
    D = pack_d(v2);
    tick();
    rst = 1'b1;
    D   = pack_d(vpos);
    tick();
    check("mid_rst", yzero);
    rst = 1'b0;
    D   = pack_d(vneg);
    tick();
    check("flush_1", yzero);
    tick();
    check("flush_2", yzero);
    tick();
    check("flush_3", yzero);
    tick();
    check("after_flush", yneg);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wc.md
WC -- requirements
Module: wc

Interface
REQ-001 The block SHALL have no parameters; widths and filter taps are package constants (REQ-020).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 D  input  80  eight signed 10-bit two's-complement samples d0..d7; d0 = D[79:70], d1 = D[69:60], ..., d7 = D[9:0].
REQ-005 Z  output  50  five signed 10-bit results y0..y4; y0 = Z[49:40], y1 = Z[39:30], ..., y4 = Z[9:0].
REQ-006 There SHALL be no valid/ready handshake; D is sampled on every rising clk edge.

Function
REQ-007 The block SHALL compute a 4-tap valid correlation: y_i = g0*d_i + g1*d_(i+1) + g2*d_(i+2) + g3*d_(i+3), for i = 0..4.
REQ-008 Taps SHALL be fixed: g0 = 1, g1 = 2, g2 = -1, g3 = 3.
REQ-009 Internal arithmetic SHALL be full precision (at least 14 bits signed); each y_i SHALL be reduced to its low 10 bits (wrap modulo 1024, no saturation, no rounding).
REQ-010 The result SHALL be bit-exact to REQ-007..REQ-009 whatever internal structure is used (direct form or Winograd F(5,4) transform / element-wise multiply / inverse transform).
REQ-011 Latency SHALL be exactly 4 clk cycles: the D value sampled at edge n appears on Z after edge n+3 and is stable before edge n+4.
REQ-012 Throughput SHALL be one new D per cycle; the pipeline is fully overlapped.
REQ-013 Z SHALL be driven from a register; it changes only on rising clk edges.
REQ-014 If D is held constant, Z SHALL hold the corresponding result indefinitely once the pipeline has filled.
REQ-015 Boundary: all d = +511 SHALL give every y = 507; all d = -512 SHALL give every y = -512 (0x200).

Reset
REQ-016 While rst = 1 at a rising edge, every pipeline register and Z SHALL be cleared to 0.
REQ-017 After rst deasserts, Z SHALL read 0 until the first post-reset D sample emerges 4 cycles later.
REQ-018 Reset asserted mid-operation SHALL flush all in-flight samples; no pre-reset data SHALL ever appear on Z afterwards.
REQ-019 rst SHALL take priority over data capture in the same cycle.

Structure
REQ-020 A shared package SHALL hold: sample width (10), input count (8), output count (5), tap count (4), the tap constants, and the internal accumulator width.
REQ-021 One sub-module, wc_dot4, is natural: a combinational signed 4-sample x fixed-tap dot product, instantiated five times.
REQ-022 Pipeline stages: input register; products; sums and wrap; output register.

Verification
REQ-023 Reset: hold rst high for 2 cycles with D nonzero -> Z = 0 during reset and for 4 cycles after release.
REQ-024 Vector 1: d = [2,-10,3,4,-13,-18,-16,-28] -> after 4 cycles y = [-9,-47,-30,-52,-117].
REQ-025 Vector 2: d = [-19,-6,3,-9,-12,11,-4,0] -> y = [-61,-27,30,-56,14].
REQ-026 Wrap: all d = +511 -> y = 507 each; all d = -512 -> y = -512 each.
REQ-027 Streaming: apply vector 1, vector 2, then all +511 on consecutive cycles -> results appear on Z on consecutive cycles, each exactly 4 cycles after its input.
REQ-028 Mid-stream reset: assert rst for one cycle while vectors are streaming -> Z = 0, with no stale result after reset, until new data has traversed the 4 stages.
